// File: rtl/quad_dec_sysid_checker_if.sv
// Avalon-MM read-only bus between the system-ID checker (master) and the Quad_Dec sysid slave.
// The master holds address/read stable while the slave asserts waitrequest.
interface quad_dec_sysid_checker_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );
endinterface

// File: rtl/quad_dec_sysid_checker.sv
// Reads sysid word 0 then word 1 and compares each against build-time constants; done 3 cycles after start
// when unstalled, each waitrequest cycle adds one, and a read stalled beyond TIMEOUT_CYCLES aborts with timeout.
module quad_dec_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1526566770,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic                            i_clock,
   input  logic                            i_reset,
   input  logic                            i_start,
   quad_dec_sysid_checker_if.master        avm_bus,
   output logic                            o_busy,
   output logic                            o_done,
   output logic                            o_id_ok,
   output logic                            o_ts_ok,
   output logic                            o_timeout,
   output logic [31:0]                     o_id_value,
   output logic [31:0]                     o_ts_value
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] STALL_LIM = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ_ID,
      S_READ_TS,
      S_DONE
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_stall;
   logic          r_done;
   logic          r_id_ok;
   logic          r_ts_ok;
   logic          r_timeout;
   logic [31:0]   r_id_value;
   logic [31:0]   r_ts_value;
   logic          w_in_read;
   logic          w_stall;
   logic          w_accept;
   logic          w_rd_done;
   logic          w_abort;

   always_comb begin
      w_state_nxt = r_state;
      w_in_read   = 1'b0;
      w_stall     = 1'b0;
      w_accept    = 1'b0;
      w_rd_done   = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_accept    = 1'b1;
               w_state_nxt = S_READ_ID;
            end
         end
         S_READ_ID, S_READ_TS: begin
            w_in_read = 1'b1;
            w_stall   = avm_bus.avm_waitrequest;
            if (!avm_bus.avm_waitrequest) begin
               w_rd_done   = 1'b1;
               w_state_nxt = (r_state == S_READ_ID) ? S_READ_TS : S_DONE;
            end else if (r_stall == STALL_LIM) begin
               // the (TIMEOUT_CYCLES+1)-th consecutive stall gives up on the slave
               w_abort     = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_stall    <= '0;
         r_done     <= 1'b0;
         r_id_ok    <= 1'b0;
         r_ts_ok    <= 1'b0;
         r_timeout  <= 1'b0;
         r_id_value <= '0;
         r_ts_value <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_stall    <= '0;
            r_done     <= 1'b0;
            r_id_ok    <= 1'b0;
            r_ts_ok    <= 1'b0;
            r_timeout  <= 1'b0;
            r_id_value <= '0;
            r_ts_value <= '0;
         end else if (w_abort) begin
            r_timeout <= 1'b1;
            r_done    <= 1'b1;
         end else if (w_rd_done) begin
            r_stall <= '0;
            if (r_state == S_READ_ID) begin
               r_id_value <= avm_bus.avm_readdata;
               r_id_ok    <= (avm_bus.avm_readdata == EXPECTED_ID);
            end else begin
               r_ts_value <= avm_bus.avm_readdata;
               r_ts_ok    <= (avm_bus.avm_readdata == EXPECTED_TIMESTAMP);
               r_done     <= 1'b1;
            end
         end else if (w_stall) begin
            r_stall <= r_stall + CW'(1);
         end
      end
   end

   assign avm_bus.avm_read    = w_in_read;
   assign avm_bus.avm_address = (r_state == S_READ_TS);
   assign o_busy              = w_in_read;
   assign o_done              = r_done;
   assign o_id_ok             = r_id_ok;
   assign o_ts_ok             = r_ts_ok;
   assign o_timeout           = r_timeout;
   assign o_id_value          = r_id_value;
   assign o_ts_value          = r_ts_value;

endmodule

// File: tb/tb_quad_dec_sysid_checker.sv
// Bench for quad_dec_sysid_checker: directed and randomized checks against a per-read outcome model.
module tb_quad_dec_sysid_checker;
   localparam logic [31:0] EXP_ID = 32'd0;
   localparam logic [31:0] EXP_TS = 32'd1526566770;
   localparam int          T      = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        busy, done, id_ok, ts_ok, timeout;
   logic [31:0] id_value, ts_value;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          sl_stall [2];
   logic [31:0] sl_data  [2];

   quad_dec_sysid_checker_if bus ();

   quad_dec_sysid_checker #(
      .EXPECTED_ID        (EXP_ID),
      .EXPECTED_TIMESTAMP (EXP_TS),
      .TIMEOUT_CYCLES     (T)
   ) dut (
      .i_clock    (clk),
      .i_reset    (reset),
      .i_start    (start),
      .avm_bus    (bus.master),
      .o_busy     (busy),
      .o_done     (done),
      .o_id_ok    (id_ok),
      .o_ts_ok    (ts_ok),
      .o_timeout  (timeout),
      .o_id_value (id_value),
      .o_ts_value (ts_value)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Slave: each new read is stalled sl_stall[addr] cycles, then returns sl_data[addr].
   initial begin
      int   cnt;
      logic prev_rd;
      logic prev_addr;
      cnt       = 0;
      prev_rd   = 1'b0;
      prev_addr = 1'b0;
      bus.avm_waitrequest = 1'b0;
      bus.avm_readdata    = '0;
      forever begin
         @(negedge clk);
         if (bus.avm_read) begin
            if (!prev_rd || bus.avm_address != prev_addr) cnt = 0;
            bus.avm_waitrequest = (cnt < sl_stall[bus.avm_address]);
            if (bus.avm_waitrequest) cnt++;
         end else begin
            bus.avm_waitrequest = 1'($urandom_range(0, 1));
         end
         bus.avm_readdata = bus.avm_waitrequest ? $urandom : sl_data[bus.avm_address];
         prev_rd   = bus.avm_read;
         prev_addr = bus.avm_address;
      end
   end

   // Starts a check (start asserted at the current negedge), follows it cycle by cycle and checks the result.
   task automatic run_check(input int s0, input int s1, input logic [31:0] d0, input logic [31:0] d1,
                            input bit dup, input bit hold);
      logic        exp_addr [$];
      logic        e_id_ok, e_ts_ok, e_tmo;
      logic [31:0] e_id, e_ts;
      e_id_ok = 1'b0; e_ts_ok = 1'b0; e_tmo = 1'b0; e_id = '0; e_ts = '0;
      sl_stall[0] = s0; sl_stall[1] = s1;
      sl_data[0]  = d0; sl_data[1]  = d1;

      if (s0 > T) begin
         e_tmo = 1'b1;
         repeat (T + 1) exp_addr.push_back(1'b0);
      end else begin
         repeat (s0 + 1) exp_addr.push_back(1'b0);
         e_id    = d0;
         e_id_ok = (d0 == EXP_ID);
         if (s1 > T) begin
            e_tmo = 1'b1;
            repeat (T + 1) exp_addr.push_back(1'b1);
         end else begin
            repeat (s1 + 1) exp_addr.push_back(1'b1);
            e_ts    = d1;
            e_ts_ok = (d1 == EXP_TS);
         end
      end

      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < exp_addr.size(); i++) begin
         if (i > 0) @(negedge clk);
         start = (dup && i == 0);
         chk("read", 32'(bus.avm_read), 32'd1);
         chk("addr", 32'(bus.avm_address), 32'(exp_addr[i]));
         chk("busy", 32'(busy), 32'd1);
         chk("done_low", 32'(done), 32'd0);
         if (i == 0) begin
            chk("clr_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
            chk("clr_id", id_value, 32'd0);
            chk("clr_ts", ts_value, 32'd0);
         end
      end
      @(negedge clk);
      start = 1'b0;
      chk("end_read", 32'(bus.avm_read), 32'd0);
      chk("end_addr", 32'(bus.avm_address), 32'd0);
      chk("end_busy", 32'(busy), 32'd0);
      chk("done", 32'(done), 32'd1);
      chk("id_ok", 32'(id_ok), 32'(e_id_ok));
      chk("ts_ok", 32'(ts_ok), 32'(e_ts_ok));
      chk("timeout", 32'(timeout), 32'(e_tmo));
      chk("id_value", id_value, e_id);
      chk("ts_value", ts_value, e_ts);
      if (hold) begin
         repeat (2) @(negedge clk);
         chk("hold_done", 32'(done), 32'd1);
         chk("hold_busy", 32'(busy), 32'd0);
         chk("hold_ts", ts_value, e_ts);
      end
   endtask

   initial begin
      logic [31:0] rid;
      reset = 1'b1;
      start = 1'b0;
      sl_stall[0] = 0; sl_stall[1] = 0;
      sl_data[0]  = EXP_ID; sl_data[1] = EXP_TS;
      repeat (3) @(negedge clk);
      chk("rst_read", 32'(bus.avm_read), 32'd0);
      chk("rst_addr", 32'(bus.avm_address), 32'd0);
      chk("rst_flags", {27'd0, busy, done, id_ok, ts_ok, timeout}, 32'd0);
      chk("rst_id", id_value, 32'd0);
      chk("rst_ts", ts_value, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      run_check(0, 0, EXP_ID, EXP_TS, 1'b0, 1'b1);           // nominal
      run_check(0, 0, EXP_ID, EXP_TS + 1, 1'b0, 1'b0);       // mismatch
      run_check(0, 0, EXP_ID, EXP_TS, 1'b0, 1'b1);           // re-run straight from DONE
      run_check(3, 0, EXP_ID, EXP_TS, 1'b0, 1'b1);           // stall on first read
      run_check(1000, 0, EXP_ID, EXP_TS, 1'b0, 1'b1);        // stuck slave
      run_check(2, 1000, 32'h1234_5678, EXP_TS, 1'b0, 1'b1); // timeout on second read keeps word 0
      run_check(T, T, EXP_ID, EXP_TS, 1'b0, 1'b1);           // longest tolerated stall
      run_check(T + 1, 0, EXP_ID, EXP_TS, 1'b0, 1'b1);       // one stall too many
      run_check(1, 2, EXP_ID, EXP_TS, 1'b1, 1'b1);           // start while busy

      // reset in the middle of the timestamp read
      rid = $urandom | 32'h1;
      sl_stall[0] = 0; sl_stall[1] = 5;
      sl_data[0]  = rid; sl_data[1] = EXP_TS;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre_rst_addr", 32'(bus.avm_address), 32'd1);
      chk("pre_rst_id", id_value, rid);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_read", 32'(bus.avm_read), 32'd0);
      chk("mid_rst_flags", {27'd0, busy, done, id_ok, ts_ok, timeout}, 32'd0);
      chk("mid_rst_id", id_value, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {30'd0, busy, bus.avm_read}, 32'd0);
      run_check(0, 0, EXP_ID, EXP_TS, 1'b0, 1'b1);

      for (int k = 0; k < 24; k++) begin
         int          s0, s1;
         logic [31:0] d0, d1;
         s0 = $urandom_range(0, T + 2);
         s1 = $urandom_range(0, T + 2);
         d0 = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
         d1 = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
         run_check(s0, s1, d0, d1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/quad_dec_sysid_checker.md
# quad_dec_sysid_checker

Avalon-MM read master that interrogates the Quad_Dec system-ID slave on request and checks both words against build-time expected values. It reads address 0 (system ID) and then address 1 (build timestamp), tolerates interconnect stalls via waitrequest, and reports pass/fail flags. It aborts with a timeout flag if the slave never responds. Software or the reset sequencer pulses `start` and then polls `done`.

## Interface
- `EXPECTED_ID`, default 0: required value of word 0.
- `EXPECTED_TIMESTAMP`, default 1526566770: required value of word 1.
- `TIMEOUT_CYCLES`, default 255, legal range 1..65535: maximum consecutive waitrequest-high cycles tolerated per read.

- `clock` in 1: the single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a check; ignored while `busy`.
- `avm_address` out 1: word address, 0 = ID, 1 = timestamp.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall; a read completes in a cycle with `avm_read`=1 and `avm_waitrequest`=0.
- `avm_readdata` in 32: read data, valid in the completing cycle (zero read latency).
- `busy` out 1: check in progress.
- `done` out 1: check finished; level, held until next accepted `start` or reset.
- `id_ok` out 1: captured ID equals `EXPECTED_ID`.
- `ts_ok` out 1: captured timestamp equals `EXPECTED_TIMESTAMP`.
- `timeout` out 1: a read exceeded `TIMEOUT_CYCLES` stall cycles.
- `id_value` out 32: captured word 0.
- `ts_value` out 32: captured word 1.

## Operation
- States: IDLE, READ_ID, READ_TS, DONE.
- **IDLE / DONE**
  - `start`=1 moves to READ_ID.
  - On that transition: clear `done`, `id_ok`, `ts_ok`, `timeout`, `id_value`, `ts_value`; clear the stall counter.
- **READ_ID**
  - Drives `avm_read`=1 and `avm_address`=0.
  - On completion: register `avm_readdata` into `id_value`, set `id_ok` = (readdata == `EXPECTED_ID`), clear the stall counter, go to READ_TS.
- **READ_TS**
  - Same as READ_ID, with address 1, `ts_value` and `ts_ok`.
  - On completion: go to DONE and set `done`=1.
- **Stall counter**
  - Width is the minimum needed to hold `TIMEOUT_CYCLES`.
  - Increments on each READ_ID/READ_TS cycle with `avm_waitrequest`=1.
  - If `avm_waitrequest`=1 in a cycle where the counter already equals `TIMEOUT_CYCLES`:
    - abort and go to DONE;
    - set `timeout`=1 and `done`=1;
    - flags for the unfinished read stay 0; values already captured are kept.
- **Outputs by state**
  - `avm_read`=1 only in READ_ID and READ_TS.
  - `avm_address` and `avm_read` are held stable throughout a stall.
  - `avm_address`=0 outside READ_TS.
  - `busy`=1 exactly in READ_ID and READ_TS.
- Comparisons are full 32-bit equality; no masking.
- `start` asserted while `busy` is ignored and has no effect on the sequence.
- **Reset**
  - Has priority over everything, including mid-read.
  - Next state is IDLE; all outputs 0; counter 0.
  - No partial read is retried; a new `start` is required.

## Timing
- All outputs are registered state decodes or registers; no combinational path from inputs to outputs except none.
- With `start` sampled at edge E and `avm_waitrequest` constantly 0:
  - READ_ID (address 0) in cycle E+1;
  - READ_TS (address 1) in cycle E+2;
  - `done`=1 and flags valid from edge E+3.
  - Minimum latency: 3 cycles.
- Each stall cycle adds one cycle to the latency.
- Worst case before `done`: 2·(`TIMEOUT_CYCLES`+1)+1 cycles.
- Timeout fires at the (`TIMEOUT_CYCLES`+1)-th consecutive stalled cycle of one read; `done` and `timeout` rise on the following edge.
- `start` in the same cycle as `done` is high (DONE state) is accepted. Flags drop at the next edge, and `busy` rises at that same edge.
- Reset values: `avm_read`=0, `avm_address`=0, `busy`=0, `done`=0, `id_ok`=0, `ts_ok`=0, `timeout`=0, `id_value`=0, `ts_value`=0.

## Test plan
- **Nominal:** slave model returns address ? 1526566770 : 0, waitrequest 0; pulse `start`.
  - Read address 0 at E+1, address 1 at E+2.
  - At E+3: `done`=1, `id_ok`=1, `ts_ok`=1, `timeout`=0, `id_value`=0, `ts_value`=1526566770.
- **Mismatch:** slave returns 1526566771 at address 1.
  - `done`=1, `id_ok`=1, `ts_ok`=0, `ts_value`=1526566771, `timeout`=0.
- **Stall:** waitrequest high for 3 cycles on the first read.
  - `avm_read`=1 and `avm_address`=0 held stable for 4 cycles.
  - `done` at E+6 with both flags 1.
- **Timeout:** `TIMEOUT_CYCLES`=8, waitrequest stuck high.
  - `avm_read` is high for exactly 9 cycles, then low.
  - `done`=1, `timeout`=1, `id_ok`=`ts_ok`=0, `busy`=0.
- **Start during busy, then reset:**
  - Second `start` during READ_ID: sequence unchanged, one check only.
  - Assert `reset` during READ_TS: next cycle all outputs 0 and state IDLE.
  - Subsequent `start` completes nominally.
- **Re-run from DONE:** after a mismatch run, fix the slave data and pulse `start`.
  - Flags clear at the next edge.
  - Final `id_ok`=`ts_ok`=1.
